// File: rtl/keypad_digit_buffer_if.sv
// rtl/keypad_digit_buffer_if.sv - keypad request lines and digit-buffer status bundle
interface keypad_digit_buffer_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic [9:0]         key;
    logic               key_del;
    logic               key_clr;
    logic               hold;
    logic [4*DEPTH-1:0] digits;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               digit_valid;
    logic               ovf;
    logic               err;

    modport master (
        output key, key_del, key_clr, hold,
        input  digits, count, full, empty, digit_valid, ovf, err
    );

    modport slave (
        input  key, key_del, key_clr, hold,
        output digits, count, full, empty, digit_valid, ovf, err
    );
endinterface

// File: rtl/keypad_digit_buffer.sv
// rtl/keypad_digit_buffer.sv - debounced 10-key keypad feeding a shift-in BCD digit buffer
module keypad_digit_buffer #(
    parameter int DEPTH      = 8,
    parameter int DEB_CYCLES = 4,
    parameter bit OVERWRITE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_ui,
    keypad_digit_buffer_if.slave  bus
);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              DW       = 4 * DEPTH;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [8:0]      DEB      = 9'(DEB_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [9:0]     r_key_q;
    logic [9:0]     r_cap;
    logic [9:0]     w_cap_next;
    logic [7:0]     r_stab;
    logic [7:0]     w_stab_next;
    logic [8:0]     w_stab_inc;
    logic           w_accept;
    logic [9:0]     w_accept_pat;
    logic           w_onehot;
    logic [3:0]     w_bcd;
    logic           w_commit;
    logic           w_multi;

    logic           r_del_prev;
    logic           w_del_edge;
    logic [DW-1:0]  r_digits;
    logic [DW-1:0]  w_digits_next;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic           r_full;
    logic           r_empty;
    logic           r_digit_valid;
    logic           w_dv_next;
    logic           r_ovf;
    logic           w_ovf_next;
    logic           r_err;

    always_ff @(posedge clk) begin
        if (rst_ui) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A press is accepted on the edge its stability count reaches DEB_CYCLES;
    // with DEB_CYCLES=1 that is the very first nonzero sample seen in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cap_next   = r_cap;
        w_stab_next  = r_stab;
        w_accept     = 1'b0;
        w_accept_pat = r_cap;
        w_stab_inc   = {1'b0, r_stab} + 9'd1;
        case (r_state)
            IDLE: begin
                if (r_key_q != 10'd0) begin
                    w_cap_next  = r_key_q;
                    w_stab_next = 8'd1;
                    if (DEB_CYCLES == 1) begin
                        w_accept     = 1'b1;
                        w_accept_pat = r_key_q;
                        w_state_next = HELD;
                    end else begin
                        w_state_next = PRESS;
                    end
                end
            end
            PRESS: begin
                if (r_key_q == 10'd0) begin
                    w_state_next = IDLE;
                end else if (r_key_q == r_cap) begin
                    w_stab_next = w_stab_inc[7:0];
                    if (w_stab_inc >= DEB) begin
                        w_accept     = 1'b1;
                        w_state_next = HELD;
                    end
                end else begin
                    w_cap_next  = r_key_q;
                    w_stab_next = 8'd1;
                end
            end
            HELD: begin
                if (r_key_q == 10'd0) begin
                    w_stab_next  = 8'd1;
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (r_key_q != 10'd0) begin
                    w_state_next = HELD;
                end else begin
                    w_stab_next = w_stab_inc[7:0];
                    if (w_stab_inc >= DEB) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_onehot = (w_accept_pat != 10'd0) &&
                   ((w_accept_pat & (w_accept_pat - 10'd1)) == 10'd0);
        w_bcd = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (w_accept_pat[k]) begin
                w_bcd = 4'(k);
            end
        end
        w_commit = w_accept && w_onehot;
        w_multi  = w_accept && !w_onehot;
    end

    assign w_del_edge = bus.key_del && !r_del_prev;

    // Priority: clear, then backspace edge, then commit; losers are dropped outright.
    always_comb begin
        w_digits_next = r_digits;
        w_count_next  = r_count;
        w_dv_next     = 1'b0;
        w_ovf_next    = 1'b0;
        if (bus.key_clr) begin
            w_digits_next = '0;
            w_count_next  = '0;
        end else if (w_del_edge) begin
            if (r_count != '0) begin
                w_digits_next = {4'd0, r_digits[DW-1:4]};
                w_count_next  = r_count - 1'b1;
            end
        end else if (w_commit && !bus.hold) begin
            if (r_count != FULL_CNT) begin
                w_digits_next = {r_digits[DW-5:0], w_bcd};
                w_count_next  = r_count + 1'b1;
                w_dv_next     = 1'b1;
            end else if (OVERWRITE) begin
                w_digits_next = {r_digits[DW-5:0], w_bcd};
                w_dv_next     = 1'b1;
                w_ovf_next    = 1'b1;
            end else begin
                w_ovf_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ui) begin
            r_key_q       <= 10'd0;
            r_cap         <= 10'd0;
            r_stab        <= 8'd0;
            r_del_prev    <= 1'b0;
            r_digits      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_digit_valid <= 1'b0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_key_q       <= bus.key;
            r_cap         <= w_cap_next;
            r_stab        <= w_stab_next;
            r_del_prev    <= bus.key_del;
            r_digits      <= w_digits_next;
            r_count       <= w_count_next;
            r_full        <= (w_count_next == FULL_CNT);
            r_empty       <= (w_count_next == '0);
            r_digit_valid <= w_dv_next;
            r_ovf         <= w_ovf_next;
            r_err         <= w_multi;
        end
    end

    assign bus.digits      = r_digits;
    assign bus.count       = r_count;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.digit_valid = r_digit_valid;
    assign bus.ovf         = r_ovf;
    assign bus.err         = r_err;
endmodule
